traffic_phase_monitor: RTL

Receive-side companion to the intersection phase controller. Consumes the controller's 3-bit phase code and 4-bit dwell count every cycle and decodes them into per-approach red/yellow/green lamp drives. Independently checks the controller's protocol (phase order and dwell lengths), and forces a safe all-red lamp pattern on any violation. Sits between the phase controller and the lamp driver pads.

---
 rtl/traffic_phase_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_monitor.sv
// Receive-side monitor for the intersection phase controller: decodes phase/count into lamp drives,
// checks phase order and dwell lengths, and forces a safe lamp pattern on violation (flash option: TPM_FLASH_EN).
module traffic_phase_monitor #(
    parameter int unsigned GREEN_LAST  = 15,
`ifdef TPM_FLASH_EN
    parameter int unsigned FLASH_HALF  = 8,
`endif
    parameter int unsigned YELLOW_LAST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] phase,
    input  logic [3:0] count,
    input  logic       fault_clr,
    output logic [2:0] lamp_n,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_w,
    output logic       err_seq,
    output logic       err_count,
    output logic       fault,
    output logic       phase_done,
    output logic [7:0] rot_cnt
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_FAULT
    } state_e;

    // Index 0..3 = north, east, south, west; matches phase[2:1].
    typedef logic [3:0][2:0] lamp_set_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [3:0] GREEN_LAST_C  = 4'(GREEN_LAST);
    localparam logic [3:0] YELLOW_LAST_C = 4'(YELLOW_LAST);

    state_e     state_q;
    logic [2:0] prev_phase_q;
    logic [3:0] prev_count_q;
    lamp_set_t  lamps_q;
    logic       err_seq_q;
    logic       err_count_q;
    logic       fault_q;
    logic       phase_done_q;
    logic [7:0] rot_cnt_q;

    logic [3:0] last_d;
    logic       change_due_d;
    logic       overrun_d;
    logic [2:0] exp_phase_d;
    logic [3:0] exp_count_d;
    logic       seq_bad_d;
    logic       cnt_bad_d;
    logic       sample_ok_d;
    logic [2:0] fault_lamp_d;

    function automatic lamp_set_t decode_lamps(input logic [2:0] ph);
        lamp_set_t l;
        l = {4{LAMP_R}};
        l[ph[2:1]] = ph[0] ? LAMP_Y : LAMP_G;
        return l;
    endfunction

    // Expected next sample derived from the previously captured one.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
        last_d       = prev_phase_q[0] ? YELLOW_LAST_C : GREEN_LAST_C;
        change_due_d = (prev_count_q == last_d);
        overrun_d    = (prev_count_q > last_d);
        exp_phase_d  = prev_phase_q;
        exp_count_d  = prev_count_q + 4'd1;
        if (change_due_d) begin
            exp_phase_d = prev_phase_q + 3'd1;
            exp_count_d = 4'd0;
        end
        seq_bad_d   = (phase != exp_phase_d);
        cnt_bad_d   = (count != exp_count_d) || overrun_d;
        sample_ok_d = !seq_bad_d && !cnt_bad_d;
    end

`ifdef TPM_FLASH_EN
    localparam int unsigned FLASH_W = (2 * FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_HALF - 1);
    localparam logic [FLASH_W-1:0] FLASH_ON   = FLASH_W'(FLASH_HALF);

    logic [FLASH_W-1:0] flash_q;
    logic [FLASH_W-1:0] flash_d;

    // flash_q indexes the flash cycle currently on the lamps; 0 is the FAULT entry cycle.
    always_comb begin
        flash_d      = (flash_q == FLASH_LAST) ? '0 : flash_q + 1'b1;
        fault_lamp_d = (flash_d < FLASH_ON) ? LAMP_R : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_q <= '0;
        end else if (state_q == ST_TRACK && !sample_ok_d) begin
            flash_q <= '0;
        end else if (state_q == ST_FAULT && !fault_clr) begin
            flash_q <= flash_d;
        end
    end
`else
    always_comb begin
        fault_lamp_d = LAMP_R;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            prev_phase_q <= 3'd0;
            prev_count_q <= 4'd0;
            lamps_q      <= {4{LAMP_R}};
            err_seq_q    <= 1'b0;
            err_count_q  <= 1'b0;
            fault_q      <= 1'b0;
            phase_done_q <= 1'b0;
            rot_cnt_q    <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments only here, so every register sees pre-edge values.
            err_seq_q    <= 1'b0;
            err_count_q  <= 1'b0;
            phase_done_q <= 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    prev_phase_q <= phase;
                    prev_count_q <= count;
                    lamps_q      <= decode_lamps(phase);
                    state_q      <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (sample_ok_d) begin
                        prev_phase_q <= phase;
                        prev_count_q <= count;
                        lamps_q      <= decode_lamps(phase);
                        phase_done_q <= (phase != prev_phase_q);
                        if (prev_phase_q == 3'd7 && phase == 3'd0) begin
                            rot_cnt_q <= rot_cnt_q + 8'd1;
                        end
                    end else begin
                        err_seq_q   <= seq_bad_d;
                        err_count_q <= cnt_bad_d;
                        fault_q     <= 1'b1;
                        lamps_q     <= {4{LAMP_R}};
                        state_q     <= ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_q <= 1'b0;
                        lamps_q <= {4{LAMP_R}};
                        state_q <= ST_INIT;
                    end else begin
                        lamps_q <= {4{fault_lamp_d}};
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign lamp_n     = lamps_q[0];
    assign lamp_e     = lamps_q[1];
    assign lamp_s     = lamps_q[2];
    assign lamp_w     = lamps_q[3];
    assign err_seq    = err_seq_q;
    assign err_count  = err_count_q;
    assign fault      = fault_q;
    assign phase_done = phase_done_q;
    assign rot_cnt    = rot_cnt_q;

endmodule
